// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK-flip-flop based counters.
// The JK command encoding is {J,K}, so a command value can be split
// straight onto the J and K pins of a cell.
package jk_pkg;

  // JK input pair as seen by a cell: {J,K}
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_cmd_t;

  // Excitation needed to move one cell from q_bit to n_bit.
  // Only HOLD, RST and SET are ever produced; a 1->1 or 0->0 transition
  // holds rather than toggling twice, so TGL never reaches the cells.
  function automatic jk_cmd_t jk_excite(input logic q_bit, input logic n_bit);
    jk_cmd_t cmd;
    unique case ({q_bit, n_bit})
      2'b01:   cmd = SET;
      2'b10:   cmd = RST;
      default: cmd = HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Single rising-edge JK flip-flop with asynchronous active-high reset.
// Implements the full JK characteristic, including toggle on J=K=1.
module jk_ff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_cmd_t cmd;

  assign cmd = jk_cmd_t'({j, k});

  // JK characteristic: hold, clear, set or toggle on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case (cmd)
        HOLD: q <= q;
        RST:  q <= 1'b0;
        SET:  q <= 1'b1;
        TGL:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state lives in WIDTH JK cells.
// The next count is decoded here, turned into per-bit J/K excitation and
// applied to the cells; the excitation vectors are exported for checking.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  // Largest legal count, and the modulus held one bit wider so that
  // MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic             at_max;
  logic             at_zero;
  logic             illegal;
  logic [WIDTH-1:0] din_sat;
  logic [WIDTH-1:0] n;

  // Decode the count boundaries and the saturated load value
  always_comb begin
    at_max  = (q == MAX_VAL);
    at_zero = (q == '0);
    illegal = ({1'b0, q} >= MOD_EXT);
    din_sat = ({1'b0, din} >= MOD_EXT) ? MAX_VAL : din;
  end

  // Next count: load beats enable; wraps are decoded before the add or
  // subtract so the arithmetic never overflows. An out-of-range count
  // (only reachable by forcing) recovers to zero on any step.
  always_comb begin
    n = q;
    if (load) begin
      n = din_sat;
    end else if (en) begin
      if (illegal) begin
        n = '0;
      end else if (up) begin
        n = at_max ? '0 : q + WIDTH'(1);
      end else begin
        n = at_zero ? MAX_VAL : q - WIDTH'(1);
      end
    end
  end

  // Terminal count: an enabled, unloaded step is about to wrap
  always_comb begin
    tc = en & ~load & ((up & at_max) | (~up & at_zero));
  end

  // One JK cell per state bit, driven by the excitation for q -> n
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cmd_t cmd;

      assign cmd       = jk_excite(q[gi], n[gi]);
      assign j_vec[gi] = cmd[1];
      assign k_vec[gi] = cmd[0];

      jk_ff u_ff (
        .clk (clk),
        .rst (rst),
        .j   (j_vec[gi]),
        .k   (k_vec[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  // Sticky wrap flag: set on a wrapping edge, cleared by load or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrapped <= 1'b0;
    end else if (load) begin
      wrapped <= 1'b0;
    end else if (tc) begin
      wrapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed and randomized bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc;
  logic       wrapped;
  logic [3:0] j_vec;
  logic [3:0] k_vec;

  int checks;
  int errors;

  jk_mod_counter #(
    .WIDTH   (4),
    .MODULUS (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .din     (din),
    .q       (q),
    .tc      (tc),
    .wrapped (wrapped),
    .j_vec   (j_vec),
    .k_vec   (k_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Parallel-load a value (setup only, no comparisons)
  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    din  = v;
    en   = 1'b0;
    step();
    load = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
    #3;
    checks++;
    if (q !== 4'd0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL reset_init q=%0d wrapped=%b expected q=0 wrapped=0", q, wrapped);
    end
    step();
    rst = 1'b0;
    en  = 1'b1;
    up  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (q !== 4'd3) begin
      errors++;
      $display("FAIL reset_count3 q=%0d expected 3", q);
    end
    $display("test_reset: q=%0d", q);
  endtask

  task automatic test_up_wrap();
    do_load(4'd9);
    en = 1'b1; up = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b1 || j_vec !== 4'b0000 || k_vec !== 4'b1001) begin
      errors++;
      $display("FAIL up_wrap_excite tc=%b j=%b k=%b expected tc=1 j=0000 k=1001", tc, j_vec, k_vec);
    end
    step();
    checks++;
    if (q !== 4'd0 || wrapped !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_edge q=%0d wrapped=%b expected q=0 wrapped=1", q, wrapped);
    end
    en = 1'b0;
    step();
    checks++;
    if (q !== 4'd0 || wrapped !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_sticky q=%0d wrapped=%b expected q=0 wrapped=1", q, wrapped);
    end
    $display("test_up_wrap: q=%0d wrapped=%b", q, wrapped);
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q;
    do_load(4'd0);
    checks++;
    if (wrapped !== 1'b0) begin
      errors++;
      $display("FAIL down_load_clear wrapped=%b expected 0", wrapped);
    end
    en = 1'b1; up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap_tc tc=%b expected 1", tc);
    end
    exp_q = 4'd0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ((j_vec & k_vec) !== 4'b0000) begin
        errors++;
        $display("FAIL down_no_toggle i=%0d j=%b k=%b expected j&k=0000", i, j_vec, k_vec);
      end
      step();
      exp_q = (exp_q == 4'd0) ? 4'd9 : exp_q - 4'd1;
      checks++;
      if (q !== exp_q) begin
        errors++;
        $display("FAIL down_count i=%0d q=%0d expected %0d", i, q, exp_q);
      end
    end
    checks++;
    if (q !== 4'd0 || wrapped !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap_end q=%0d wrapped=%b expected q=0 wrapped=1", q, wrapped);
    end
    $display("test_down_wrap: q=%0d wrapped=%b", q, wrapped);
  endtask

  task automatic test_load();
    // wrapped is set from the previous test; load must clear it
    load = 1'b1; din = 4'd13; en = 1'b1; up = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL load_sat_tc tc=%b expected 0", tc);
    end
    step();
    checks++;
    if (q !== 4'd9 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL load_saturate q=%0d wrapped=%b expected q=9 wrapped=0", q, wrapped);
    end
    // Loading at the top while a wrap would otherwise happen
    din = 4'd9;
    #1;
    checks++;
    if (tc !== 1'b0 || j_vec !== 4'b0000 || k_vec !== 4'b0000) begin
      errors++;
      $display("FAIL load_priority_comb tc=%b j=%b k=%b expected tc=0 j=0000 k=0000", tc, j_vec, k_vec);
    end
    step();
    checks++;
    if (q !== 4'd9 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL load_priority q=%0d wrapped=%b expected q=9 wrapped=0", q, wrapped);
    end
    load = 1'b0; en = 1'b0;
    #1;
    $display("test_load: q=%0d wrapped=%b", q, wrapped);
  endtask

  task automatic test_hold();
    do_load(4'd6);
    en = 1'b0; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (j_vec !== 4'b0000 || k_vec !== 4'b0000) begin
        errors++;
        $display("FAIL hold_excite i=%0d j=%b k=%b expected 0000/0000", i, j_vec, k_vec);
      end
      step();
      checks++;
      if (q !== 4'd6) begin
        errors++;
        $display("FAIL hold_q i=%0d q=%0d expected 6", i, q);
      end
    end
    $display("test_hold: q=%0d", q);
  endtask

  task automatic test_back_to_back();
    // Direction change with no dead cycle, then reset mid-count
    do_load(4'd8);
    en = 1'b1; up = 1'b1;
    step();
    up = 1'b0;
    step();
    checks++;
    if (q !== 4'd8) begin
      errors++;
      $display("FAIL dir_change q=%0d expected 8", q);
    end
    up = 1'b1;
    step();
    step();
    checks++;
    if (q !== 4'd0 || wrapped !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap q=%0d wrapped=%b expected q=0 wrapped=1", q, wrapped);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL async_reset q=%0d wrapped=%b expected q=0 wrapped=0", q, wrapped);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (q !== 4'd1) begin
      errors++;
      $display("FAIL reset_resume q=%0d expected 1", q);
    end
    $display("test_back_to_back: q=%0d", q);
  endtask

  task automatic test_random();
    logic [3:0] exp_q;
    logic       exp_wr;
    logic       exp_tc;
    logic [3:0] jk_q;
    logic [3:0] pj;
    logic [3:0] pk;
    logic [3:0] pq;
    int         err_start;
    err_start = errors;
    do_load(4'd0);
    exp_q  = 4'd0;
    exp_wr = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      en   = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      din  = 4'($urandom_range(0, 15));
      #1;
      exp_tc = en & ~load & ((up & (exp_q == 4'd9)) | (~up & (exp_q == 4'd0)));
      checks++;
      if ((j_vec & k_vec) !== 4'b0000 || tc !== exp_tc) begin
        errors++;
        if (errors - err_start < 10)
          $display("FAIL rand_comb c=%0d j=%b k=%b tc=%b expected j&k=0000 tc=%b", c, j_vec, k_vec, tc, exp_tc);
      end
      pq = q; pj = j_vec; pk = k_vec;
      if (load) begin
        exp_wr = 1'b0;
        exp_q  = (din >= 4'd10) ? 4'd9 : din;
      end else if (en) begin
        if (exp_tc) exp_wr = 1'b1;
        if (up) exp_q = (exp_q == 4'd9) ? 4'd0 : exp_q + 4'd1;
        else    exp_q = (exp_q == 4'd0) ? 4'd9 : exp_q - 4'd1;
      end
      for (int b = 0; b < 4; b++) begin
        case ({pj[b], pk[b]})
          2'b00:   jk_q[b] = pq[b];
          2'b01:   jk_q[b] = 1'b0;
          2'b10:   jk_q[b] = 1'b1;
          default: jk_q[b] = ~pq[b];
        endcase
      end
      step();
      checks++;
      if (q !== exp_q || q !== jk_q || wrapped !== exp_wr) begin
        errors++;
        if (errors - err_start < 10)
          $display("FAIL rand_step c=%0d q=%0d wrapped=%b expected q=%0d (jk table %0d) wrapped=%b",
                   c, q, wrapped, exp_q, jk_q, exp_wr);
      end
    end
    load = 1'b0; en = 1'b0;
    $display("test_random: 10000 cycles, errors so far %0d", errors);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
